// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single memory port between the instruction-fetch requester
//   (imem) and the load/store requester (dmem). Each side owns a one-entry
//   pending buffer, where the newest request overwrites the older one. Data
//   requests win by default. A starvation counter forces an instruction
//   grant after STARVE_LIMIT consecutive data grants made while imem waits.
//   Only one transaction is outstanding at a time. Its response is routed
//   combinationally back to the side that owns it.
//
// Ports
//   clk       clock
//   rst       synchronous, active-low reset
//   imem_in   [69:0] fetch request   {valid, instr, addr[31:0], wdata[31:0], wstrb[3:0]}
//   imem_out  [32:0] fetch response  {ready, rdata[31:0]}
//   dmem_in   [69:0] load/store request (same layout as imem_in)
//   dmem_out  [32:0] load/store response (same layout as imem_out)
//   mem_in    [69:0] request to the shared memory
//   mem_out   [32:0] response from the shared memory

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [69:0] imem_in,
    output logic [32:0] imem_out,
    input  logic [69:0] dmem_in,
    output logic [32:0] dmem_out,
    output logic [69:0] mem_in,
    input  logic [32:0] mem_out
);

    localparam int SIDE_I = 0;
    localparam int SIDE_D = 1;
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t         state_reg;
    logic [CW-1:0]  starve_cnt_reg;

    logic [1:0][69:0] req_in;
    logic [1:0][68:0] pend_fields;
    logic [1:0]       pend_valid;
    logic [1:0]       issue;

    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        can_issue;
    logic        sel_i;

    assign req_in[SIDE_I] = imem_in;
    assign req_in[SIDE_D] = dmem_in;
    assign mem_ready      = mem_out[32];
    assign mem_rdata      = mem_out[31:0];

    // One-entry pending buffer per requester. A new valid request always
    // wins over clearing on issue, so a request presented in its own side's
    // issue cycle stays pending with the new fields.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            logic [68:0] fields_reg;
            logic        valid_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_reg  <= 1'b0;
                    fields_reg <= '0;
                end else if (req_in[gi][69]) begin
                    valid_reg  <= 1'b1;
                    fields_reg <= req_in[gi][68:0];
                end else if (issue[gi]) begin
                    valid_reg  <= 1'b0;
                end
            end

            assign pend_fields[gi] = fields_reg;
            assign pend_valid[gi]  = valid_reg;
        end
    endgenerate

    // The port is free in IDLE. It is also free in the completion cycle of
    // a busy state, because the memory accepts a new request alongside
    // mem_ready.
    always_comb begin
        can_issue = (state_reg == IDLE) || mem_ready;
        sel_i     = pend_valid[SIDE_I] &&
                    (!pend_valid[SIDE_D] || (starve_cnt_reg == STARVE_MAX));
        issue[SIDE_I] = can_issue && sel_i;
        issue[SIDE_D] = can_issue && pend_valid[SIDE_D] && !sel_i;
    end

    always_comb begin
        mem_in = '0;
        if (issue[SIDE_I]) begin
            mem_in = {1'b1, pend_fields[SIDE_I]};
        end else if (issue[SIDE_D]) begin
            mem_in = {1'b1, pend_fields[SIDE_D]};
        end
    end

    // The response goes only to the owner of the outstanding transaction.
    // A stray mem_ready in IDLE reaches neither side.
    always_comb begin
        imem_out = '0;
        dmem_out = '0;
        if (mem_ready && (state_reg == BUSY_I)) begin
            imem_out = {1'b1, mem_rdata};
        end
        if (mem_ready && (state_reg == BUSY_D)) begin
            dmem_out = {1'b1, mem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            if (issue[SIDE_I]) begin
                state_reg <= BUSY_I;
            end else if (issue[SIDE_D]) begin
                state_reg <= BUSY_D;
            end else if ((state_reg != IDLE) && mem_ready) begin
                state_reg <= IDLE;
            end

            // The count measures data grants made while a fetch is waiting.
            if (issue[SIDE_I] || !pend_valid[SIDE_I]) begin
                starve_cnt_reg <= '0;
            end else if (issue[SIDE_D] && (starve_cnt_reg != STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch requester (imem) and the load/store requester (dmem). Each requester gets a one-entry pending buffer. A fixed data-first policy with an instruction starvation guard selects the next request. One transaction is outstanding on the shared port at a time, and its response is routed back to the requester that owns it. The block sits between the fetch/memory stages and the external memory bus.

## Interface
- STARVE_LIMIT, default 4: consecutive dmem grants allowed while imem is pending; after that, imem is forced.
- rst input 1: synchronous, active-low reset.
- clk input 1: clock.
- imem_in input 70: mem_in_type from fetch. Fields: mem_valid[1], mem_instr[1], mem_addr[32], mem_wdata[32], mem_wstrb[4].
- imem_out output 33: mem_out_type to fetch. Fields: mem_ready[1], mem_rdata[32].
- dmem_in input 70: mem_in_type from the memory stage.
- dmem_out output 33: mem_out_type to the memory stage.
- mem_in output 70: mem_in_type to the shared memory.
- mem_out input 33: mem_out_type from the shared memory.

## Operation
- Pending buffers pend_i and pend_d each hold valid plus all mem_in_type fields.
  - Any cycle with X_in.mem_valid=1 writes pend_X at the clock edge and overwrites older contents (newest wins).
  - A pending request that is overwritten before issue is dropped silently. This is intended, because fetch re-issues speculatively.
- States:
  - IDLE: nothing outstanding.
  - BUSY_I: imem transaction outstanding.
  - BUSY_D: dmem transaction outstanding.
- Issue:
  - A request is issued in IDLE, or in the BUSY cycle where mem_out.mem_ready=1.
  - Issue drives mem_in combinationally from the selected pend register, with mem_valid=1 for exactly one cycle.
  - At the edge, the state becomes BUSY of the selected side and that pend valid clears.
  - The pend valid stays set instead of clearing if the same side presents a new valid in the issue cycle; the new fields are captured.
- Selection when both are pending:
  - Default: dmem wins.
  - If starve_cnt == STARVE_LIMIT, imem wins.
- starve_cnt:
  - Increments on each dmem grant while pend_i is valid, saturating at STARVE_LIMIT.
  - Clears on any imem grant, and whenever pend_i is invalid.
- Completion:
  - In BUSY_X with mem_out.mem_ready=1, X_out.mem_ready=1 and X_out.mem_rdata=mem_out.mem_rdata in the same cycle (combinational).
  - The state returns to IDLE unless a new issue happens that same cycle.
- Non-owner outputs: mem_ready=0 and mem_rdata=0.
- In IDLE, mem_out.mem_ready is ignored and not routed to either requester.
- When not issuing, mem_in is all zero.
- An issued request cannot be cancelled; its response is always delivered to its owner.

## Timing
- Reset (rst=0 at an edge):
  - State becomes IDLE; both pend valids, all pend fields and starve_cnt clear.
  - All outputs are 0 from the first cycle after reset.
  - A transaction outstanding at reset is abandoned, and its late mem_ready is ignored.
- Latency: request valid at cycle t → mem_in.mem_valid at t+1, if the port is free.
- Response: X_out.mem_ready in the same cycle as mem_out.mem_ready.
- Back-to-back: the completion cycle can issue the next request, so zero idle cycles occur between transactions.
- Throughput: one transaction per memory latency.
- The memory must accept a new mem_valid in the same cycle it asserts mem_ready.
- Memory latency ≥1 cycle after the issue cycle; mem_ready in the issue cycle itself is not allowed.

## Test plan
- Single fetch:
  - Stimulus: imem_in valid with addr 0x100 at cycle 0; memory responds at cycle 3 with rdata 0x00000013.
  - Required: mem_in.mem_valid=1 with addr 0x100 and mem_instr=1 at cycle 1 only; imem_out ready with rdata 0x13 at cycle 3; dmem_out stays 0.
- Collision:
  - Stimulus: imem 0x200 and dmem 0x8000 (wstrb 0xF, wdata 0xDEADBEEF) both valid at cycle 0.
  - Required: dmem is issued at cycle 1; imem is issued in dmem's completion cycle.
- Starvation:
  - Stimulus: dmem continuously valid; imem valid once with STARVE_LIMIT=4.
  - Required: exactly 4 dmem grants, then the imem grant, then dmem resumes.
- Overwrite:
  - Stimulus: while BUSY_D, imem presents 0x300 then 0x304 on consecutive cycles.
  - Required: only 0x304 is issued; 0x300 never appears on mem_in.
- Reset mid-transaction:
  - Stimulus: rst=0 one cycle while BUSY_I, then mem_ready=1 arrives.
  - Required: imem_out.mem_ready stays 0; state is IDLE; the next request issues normally.
- Back-to-back same side:
  - Stimulus: dmem valid again in its own issue cycle.
  - Required: the second request issues in the first request's completion cycle.
